mem_stage: RTL and testbench

//   Memory-access pipeline stage between EX and WB of the AZ8 pipelined core.

---
 rtl/az8_pkg.sv | 23 ++
 rtl/mem_timeout_ctr.sv | 39 +++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/az8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : az8_pkg
// Description : Shared AZ8 core widths, MEM-stage FSM encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package az8_pkg;

  // Default widths used across the AZ8 pipeline
  localparam int AZ8_ADDR_LEN  = 5;
  localparam int AZ8_WORD_SIZE = 32;

  // MEM-stage FSM encoding
  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  // Word accesses require the two low byte-address bits to be zero
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage : az8_pkg
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Cycle counter for an outstanding memory request; flags the
//               last permitted wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr
  import az8_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   c_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count wait cycles; clear has priority so a fresh request starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == c_LAST);

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : AZ8 memory-access stage between EX and WB. Registers ALU
//               results, runs word loads/stores over a req/ack port and
//               stalls upstream while an access is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import az8_pkg::*;
#(
  parameter int ADDR_LEN  = AZ8_ADDR_LEN,
  parameter int WORD_SIZE = AZ8_WORD_SIZE,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 reg_write_i,
  input  logic [ADDR_LEN-1:0]  dst_addr_i,
  input  logic [WORD_SIZE-1:0] alu_result_i,
  input  logic [WORD_SIZE-1:0] store_data_i,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  output logic [ADDR_LEN-1:0]  dst_addr_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 reg_write_o,
  output logic                 err_o
);

  logic [0:0]           r_state;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [ADDR_LEN-1:0]  r_lat_dst;
  logic                 r_lat_reg_write;
  logic [ADDR_LEN-1:0]  r_dst_addr;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_reg_write;
  logic                 r_err;

  logic w_in_wait;
  logic w_mem_op;
  logic w_aligned;
  logic w_expired;

  assign w_in_wait = (r_state == c_WAIT);
  assign w_mem_op  = mem_read_i | mem_write_i;
  assign w_aligned = is_word_aligned(alu_result_i[1:0]);

  // Counter sits at zero while idle, so every request starts a fresh budget
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (~w_in_wait),
    .en      (w_in_wait),
    .expired (w_expired)
  );

  // Stage FSM plus WB-facing and memory-port pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= c_IDLE;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_lat_dst       <= '0;
      r_lat_reg_write <= 1'b0;
      r_dst_addr      <= '0;
      r_data          <= '0;
      r_reg_write     <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // Default is a bubble; only a retiring ALU op raises the pulse
          r_reg_write <= 1'b0;
          if (valid_i) begin
            if (!w_mem_op) begin
              r_dst_addr  <= dst_addr_i;
              r_data      <= alu_result_i;
              r_reg_write <= reg_write_i;
            end else if (!w_aligned) begin
              r_err <= 1'b1;
            end else begin
              // A read+write request is issued as a store
              r_mem_addr      <= alu_result_i;
              r_mem_wdata     <= store_data_i;
              r_mem_we        <= mem_write_i;
              r_lat_dst       <= dst_addr_i;
              r_lat_reg_write <= reg_write_i;
              r_mem_req       <= 1'b1;
              r_state         <= c_WAIT;
            end
          end
        end
        c_WAIT: begin
          // Ack beats timeout when both land on the same cycle
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= c_IDLE;
            if (!r_mem_we) begin
              r_data      <= mem_rdata_i;
              r_dst_addr  <= r_lat_dst;
              r_reg_write <= r_lat_reg_write;
            end
          end else if (w_expired) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign stall_o     = w_in_wait;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign dst_addr_o  = r_dst_addr;
  assign data_o      = r_data;
  assign reg_write_o = r_reg_write;
  assign err_o       = r_err;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed scenarios plus
//               randomized instruction streams against a transaction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int AL = 5;
  localparam int WS = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i, mem_read_i, mem_write_i, reg_write_i;
  logic [AL-1:0] dst_addr_i;
  logic [WS-1:0] alu_result_i, store_data_i, mem_rdata_i;
  logic          mem_ack_i;
  logic          stall_o, mem_req_o, mem_we_o, reg_write_o, err_o;
  logic [WS-1:0] mem_addr_o, mem_wdata_o, data_o;
  logic [AL-1:0] dst_addr_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: what WB should currently see
  logic [AL-1:0] m_dst;
  logic [WS-1:0] m_data;
  logic          m_err;

  mem_stage #(.ADDR_LEN(AL), .WORD_SIZE(WS), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .reg_write_i  (reg_write_i),
    .dst_addr_i   (dst_addr_i),
    .alu_result_i (alu_result_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .dst_addr_o   (dst_addr_o),
    .data_o       (data_o),
    .reg_write_o  (reg_write_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_dst"}, 32'(dst_addr_o), 32'(m_dst));
    check({tag, "_data"}, data_o, m_data);
    check({tag, "_err"}, 32'(err_o), 32'(m_err));
  endtask

  task automatic clear_inputs();
    valid_i      = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    reg_write_i  = 1'b0;
    dst_addr_i   = '0;
    alu_result_i = '0;
    store_data_i = '0;
  endtask

  // Idle cycle, optionally with a stray ack that must be ignored
  task automatic bubble(input bit stray_ack);
    clear_inputs();
    mem_ack_i   = stray_ack;
    mem_rdata_i = $urandom;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    check("bub_rw", 32'(reg_write_o), 32'd0);
    check("bub_req", 32'(mem_req_o), 32'd0);
    check("bub_stall", 32'(stall_o), 32'd0);
    check_wb("bub");
  endtask

  // One instruction; lat = WAIT cycle in which memory acks (> TO means never)
  task automatic run_op(input bit rd, input bit wr, input bit rw, input logic [AL-1:0] dst,
                        input logic [WS-1:0] alu, input logic [WS-1:0] sd,
                        input int lat, input logic [WS-1:0] rdata);
    int  req_cycles;
    bit  done;
    bit  is_store;
    valid_i      = 1'b1;
    mem_read_i   = rd;
    mem_write_i  = wr;
    reg_write_i  = rw;
    dst_addr_i   = dst;
    alu_result_i = alu;
    store_data_i = sd;
    mem_ack_i    = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    if (!(rd || wr)) begin
      m_dst  = dst;
      m_data = alu;
      check("alu_rw", 32'(reg_write_o), 32'(rw));
      check("alu_stall", 32'(stall_o), 32'd0);
      check("alu_req", 32'(mem_req_o), 32'd0);
      check_wb("alu");
    end else if (alu[1:0] != 2'b00) begin
      m_err = 1'b1;
      check("mis_rw", 32'(reg_write_o), 32'd0);
      check("mis_req", 32'(mem_req_o), 32'd0);
      check("mis_stall", 32'(stall_o), 32'd0);
      check_wb("mis");
    end else begin
      is_store = wr;
      check("req_on", 32'(mem_req_o), 32'd1);
      check("req_we", 32'(mem_we_o), 32'(is_store));
      check("req_addr", mem_addr_o, alu);
      if (is_store) check("req_wdata", mem_wdata_o, sd);
      check("req_stall", 32'(stall_o), 32'd1);
      check("req_rw", 32'(reg_write_o), 32'd0);
      req_cycles = 1;
      done       = 1'b0;
      for (int k = 1; k <= TO + 4 && !done; k++) begin
        mem_ack_i   = (k == lat);
        mem_rdata_i = (k == lat) ? rdata : WS'($urandom);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        if (!stall_o) begin
          done = 1'b1;
        end else begin
          if (mem_req_o) req_cycles++;
          check("wait_rw", 32'(reg_write_o), 32'd0);
          check("wait_addr", mem_addr_o, alu);
        end
      end
      if (!done) check("wait_bound", 32'd0, 32'd1);
      check("req_cycles", 32'(req_cycles), 32'((lat <= TO) ? lat : TO));
      if (lat <= TO) begin
        if (!is_store) begin
          m_dst  = dst;
          m_data = rdata;
          check("ld_rw", 32'(reg_write_o), 32'(rw));
        end else begin
          check("st_rw", 32'(reg_write_o), 32'd0);
        end
      end else begin
        m_err = 1'b1;
        check("to_rw", 32'(reg_write_o), 32'd0);
      end
      check("done_req", 32'(mem_req_o), 32'd0);
      check("done_stall", 32'(stall_o), 32'd0);
      check_wb("done");
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_dst", 32'(dst_addr_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_rw", 32'(reg_write_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    m_dst  = '0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  initial begin
    logic [WS-1:0] a;
    int            kind;
    int            lat;
    rst = 1'b0;
    clear_inputs();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    #2;
    apply_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bubble(1'b0);

    // Directed scenarios
    run_op(0, 0, 1, 5'd3, 32'h0000_1234, 32'h0, 0, 32'h0);
    bubble(1'b0);                                       // pulse is one cycle
    run_op(1, 0, 1, 5'd7, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);
    bubble(1'b0);
    run_op(0, 1, 0, 5'd0, 32'h0000_0010, 32'hA5A5_A5A5, 1, 32'h0);
    run_op(1, 1, 1, 5'd9, 32'h0000_0020, 32'h1111_2222, 2, 32'h0); // both set: store
    run_op(1, 0, 1, 5'd4, 32'h0000_0080, 32'h0, TO, 32'hCAFE_F00D); // ack at timeout wins
    bubble(1'b1);
    run_op(1, 0, 1, 5'd2, 32'h0000_0041, 32'h0, 1, 32'h0);          // misaligned
    bubble(1'b0);

    // Async reset while a request is outstanding
    valid_i      = 1'b1;
    mem_read_i   = 1'b1;
    reg_write_i  = 1'b1;
    dst_addr_i   = 5'd6;
    alu_result_i = 32'h0000_0100;
    @(posedge clk); #1;
    clear_inputs();
    check("pre_rst_req", 32'(mem_req_o), 32'd1);
    @(posedge clk); #3;
    apply_reset();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b0;
    bubble(1'b1);
    run_op(0, 0, 1, 5'd3, 32'h0000_1234, 32'h0, 0, 32'h0);

    // Timeout with no ack, then a normal ALU op
    run_op(1, 0, 1, 5'd8, 32'h0000_0200, 32'h0, 1000, 32'h0);
    run_op(0, 0, 1, 5'd12, 32'h0BAD_F00D, 32'h0, 0, 32'h0);

    // Randomized instruction stream
    apply_reset();
    @(negedge clk) rst = 1'b0;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      lat  = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(1, TO);
      run_op(kind == 1 || kind == 3, kind >= 2, 1'($urandom), AL'($urandom), a,
             WS'($urandom), lat, WS'($urandom));
      if ($urandom_range(0, 2) == 0) bubble(1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_stage
`default_nettype wire
